// File: rtl/counter_modn_updown_pkg.sv
// Shared definitions for the up/down modulo counter: direction encodings and width helper.
package counter_modn_updown_pkg;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Width needed to hold values 0..x inclusive, so the maximum modulus itself is representable.
  function automatic int unsigned bits(input int unsigned x);
    return $clog2(x + 1);
  endfunction

endpackage

// File: rtl/counter_next_logic.sv
// Combinational step computation for the modulo counter: next count, terminal flag, wrap flag.
module counter_next_logic
  import counter_modn_updown_pkg::*;
#(
  parameter int unsigned W = 6
) (
  input  logic [W-1:0] cnt,
  input  logic         dir,
  input  logic [W-1:0] m_max,
  output logic [W-1:0] nxt,
  output logic         term,
  output logic         wrap_nxt
);

  always_comb begin
    nxt      = cnt;
    term     = 1'b0;
    wrap_nxt = 1'b0;
    if (dir == DIR_UP) begin
      term = (cnt == m_max);
      // Covers both the terminal count and a count stranded above a lowered modulus.
      if (cnt >= m_max) begin
        nxt      = '0;
        wrap_nxt = 1'b1;
      end else begin
        nxt = cnt + W'(1);
      end
    end else begin
      term = (cnt == '0);
      if (cnt == '0) begin
        nxt      = m_max;
        wrap_nxt = 1'b1;
      end else if (cnt > m_max) begin
        nxt = m_max;
      end else begin
        nxt = cnt - W'(1);
      end
    end
  end

endmodule

// File: rtl/counter_modn_updown.sv
// Up/down modulo counter with run-time modulus, load, optional saturation and cascade carry.
module counter_modn_updown
  import counter_modn_updown_pkg::*;
#(
  parameter int unsigned N   = 32,
  parameter bit          SAT = 1'b0,
  localparam int unsigned W  = bits(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         dir,
  input  logic [W-1:0] mod_val,
  output logic [W-1:0] cnt,
  output logic         co,
  output logic         co_en,
  output logic         wrap,
  output logic         ovf
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         wrap_q, wrap_d;
  logic         ovf_q, ovf_d;
  logic [W-1:0] m, m_max;
  logic [W-1:0] nxt;
  logic         term, wrap_nxt;

  // A zero modulus selects the full range N.
  assign m     = (mod_val == '0) ? W'(N) : mod_val;
  assign m_max = m - W'(1);

  counter_next_logic #(
    .W (W)
  ) u_next (
    .cnt      (cnt_q),
    .dir      (dir),
    .m_max    (m_max),
    .nxt      (nxt),
    .term     (term),
    .wrap_nxt (wrap_nxt)
  );

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (ld) begin
      cnt_d = (ld_val > m_max) ? m_max : ld_val;
    end else if (en) begin
      if (term) begin
        ovf_d = 1'b1;
      end
      if (!(term && SAT)) begin
        cnt_d  = nxt;
        wrap_d = wrap_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign cnt   = cnt_q;
  assign co    = term;
  assign co_en = term & en;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;

endmodule
